// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default address width, Gray conversions and the
// full-compare used by the write side (and later the read side).
// Functions work on 32-bit zero-extended values; callers cast to their width.
package fifo_pkg;

    localparam int unsigned FIFO_ADDRSIZE = 8;
    localparam int unsigned FIFO_FNW      = 32;

    // Binary to reflected Gray code.
    function automatic logic [FIFO_FNW-1:0] bin_to_gray(input logic [FIFO_FNW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FIFO_FNW-1:0] gray_to_bin(input logic [FIFO_FNW-1:0] g);
        logic [FIFO_FNW-1:0] b;
        b[FIFO_FNW-1] = g[FIFO_FNW-1];
        for (int i = FIFO_FNW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Full when our next Gray pointer equals the other side's Gray pointer
    // with its two MSBs (of a w-bit pointer) inverted.
    function automatic logic gray_full_match(input logic [FIFO_FNW-1:0] gnext,
                                             input logic [FIFO_FNW-1:0] gother,
                                             input int unsigned         w);
        logic [FIFO_FNW-1:0] mask;
        mask = FIFO_FNW'(3) << (w - 2);
        return gnext == (gother ^ mask);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
// Ports: gray (WIDTH, Gray input), bin (WIDTH, binary output).
module gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_ADDRSIZE + 1
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray_to_bin(FIFO_FNW'(gray)));

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller of the asynchronous FIFO.
// Keeps binary/Gray write pointers, SRAM write address and registered
// full / almost-full / fill-level / sticky-overflow status.
// Ports:
//   wclk, wrst_n (sync, active-low)    write clock and reset
//   winc                               write request
//   wq2_rptr [ADDRSIZE:0]              synchronised Gray read pointer
//   afull_thresh [ADDRSIZE:0]          almost-full threshold in words
//   ovf_clr                            clears wovf
//   waddr [ADDRSIZE-1:0]               SRAM write address
//   wptr [ADDRSIZE:0]                  registered Gray write pointer
//   wfull, wafull                      registered full / almost-full
//   wcount [ADDRSIZE:0]                registered fill level 0..DEPTH
//   wovf                               sticky overflow flag
// Config macro: WPTR_FULL_OVF_EN enables wovf; otherwise wovf is tied 0.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                ovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] count_next;
    logic          accept_c;
    logic          full_next;
    logic          afull_next;

    // Read pointer back to binary for the fill-level subtraction.
    gray2bin #(.WIDTH(PW)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Next-state pointer and status, all from the current synchronised rptr.
    assign accept_c   = winc & ~wfull;
    assign wbinnext   = wbin + PW'(accept_c);
    assign wgraynext  = PW'(bin_to_gray(FIFO_FNW'(wbinnext)));
    assign full_next  = gray_full_match(FIFO_FNW'(wgraynext), FIFO_FNW'(wq2_rptr), PW);
    assign count_next = wbinnext - rbin;
    assign afull_next = (count_next >= afull_thresh);

    assign waddr = wbin[ADDRSIZE-1:0];

    // Pointer and status registers.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wcount <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= full_next;
            wafull <= afull_next;
            wcount <= count_next;
        end
    end

`ifdef WPTR_FULL_OVF_EN
    // Sticky overflow: a dropped write sets it; set has priority over clear.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (ovf_clr) begin
            wovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;

    always_ff @(posedge wclk) begin
        wovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl at ADDRSIZE=4 (DEPTH 16).
module tb_wptr_full_ctrl;

    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic [AW:0]   afull_thresh;
    logic          ovf_clr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wcount;
    logic          wovf;

    wptr_full_ctrl #(.ADDRSIZE(AW)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .afull_thresh (afull_thresh),
        .ovf_clr      (ovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wafull       (wafull),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int   waddr;
        int   wptr;
        bit   wfull;
        bit   wafull;
        int   wcount;
        bit   wovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: total words written / read as plain integers.
    int m_wr   = 0;
    int m_rd   = 0;
    bit m_full = 0;
    bit m_afull = 0;
    bit m_ovf  = 0;
    int rd     = 0;
    int thresh = 12;

    function automatic int gray_of(input int v);
        int b;
        b = v % 32;
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, then advance the model across the edge and queue the result.
    task automatic step(input bit w, input int adv, input bit clr, input bit rst);
        int cnt;
        exp_t e;
        if (rst) rd = 0;
        else if (rd + adv <= m_wr) rd = rd + adv;
        winc         = w;
        wrst_n       = ~rst;
        ovf_clr      = clr;
        wq2_rptr     = 5'(gray_of(rd));
        afull_thresh = 5'(thresh);
        @(posedge wclk);
        if (rst) begin
            m_wr = 0; m_full = 0; m_afull = 0; m_ovf = 0; cnt = 0;
        end else begin
`ifdef WPTR_FULL_OVF_EN
            if (w && m_full) m_ovf = 1;
            else if (clr)    m_ovf = 0;
`else
            m_ovf = 0;
`endif
            if (w && !m_full) m_wr++;
            cnt     = m_wr - rd;
            m_full  = (cnt == DEPTH);
            m_afull = (cnt >= thresh);
        end
        e.waddr  = m_wr % DEPTH;
        e.wptr   = gray_of(m_wr);
        e.wfull  = m_full;
        e.wafull = m_afull;
        e.wcount = cnt;
        e.wovf   = m_ovf;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare against queued expectations.
    always @(negedge wclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("waddr",  int'(waddr),  e.waddr);
            check("wptr",   int'(wptr),   e.wptr);
            check("wfull",  int'(wfull),  int'(e.wfull));
            check("wafull", int'(wafull), int'(e.wafull));
            check("wcount", int'(wcount), e.wcount);
            check("wovf",   int'(wovf),   int'(e.wovf));
            if (e.wfull != (e.wcount == DEPTH)) check("model_full_inv", 0, 1);
        end
    end

    initial begin
        winc = 0; wrst_n = 0; ovf_clr = 0; wq2_rptr = '0; afull_thresh = 5'(thresh);

        // Reset, then fill 16 words plus one dropped write.
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 0);              // another dropped write (overflow stays)
        step(0, 0, 0, 0);

        // Release reads until wcount falls through the almost-full threshold.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Refill, then simultaneous read release and write at full.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Overflow clear pulse, then set and clear on the same edge.
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);

        // Wrap-around with the read lagging three words.
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);

        // Mid-stream reset at wcount 9 with a write pending.
        step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);

        // Threshold corners: 0 and beyond DEPTH.
        thresh = 0;
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        thresh = 17;
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) thresh = int'($urandom_range(0, 20));
            step(bit'($urandom_range(0, 99) < 60),
                 int'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 9) == 0),
                 bit'($urandom_range(0, 149) == 0));
        end

        step(0, 0, 0, 0);
        @(negedge wclk);
        @(negedge wclk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
